// File: rtl/mouse_master_sm_if.sv
// PS/2 mouse master bus: transmitter, receiver and position/display side.
// The controller takes the master modport; the environment takes the slave modport.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: host init handshake (0xFF reset, ACK/self-test/ID,
// 0xF4 enable, ACK), then 3-byte stream packet assembly and publication.
module mouse_master_sm #(
  parameter int INIT_DELAY   = 5_000_000,
  parameter int BYTE_TIMEOUT = 2_500_000,
  parameter int CTR_W        = 23
) (
  input  logic               CLK,
  input  logic               RESET,
  mouse_master_sm_if.master  bus
);

  typedef enum logic [3:0] {
    INIT        = 4'd0,
    TX_RST      = 4'd1,
    WT_RST_SENT = 4'd2,
    WT_ACK1     = 4'd3,
    WT_SELFTEST = 4'd4,
    WT_ID       = 4'd5,
    TX_EN       = 4'd6,
    WT_EN_SENT  = 4'd7,
    WT_ACK2     = 4'd8,
    PKT0        = 4'd9,
    PKT1        = 4'd10,
    PKT2        = 4'd11,
    PUBLISH     = 4'd12
  } state_e;

  localparam logic [CTR_W-1:0] INIT_LAST = CTR_W'(INIT_DELAY - 1);
  localparam logic [CTR_W-1:0] TO_LAST   = CTR_W'(BYTE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             send_q, rd_en_q, int_q;
  logic [7:0]       tx_byte_q, status_q, dx_q, dy_q;
  logic [7:0]       s0_q, s1_q, s2_q;

  logic good, bad, tmo;

  assign good = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);
  assign bad  = bus.BYTE_READY && (bus.BYTE_ERROR_CODE != 2'b00);
  assign tmo  = (ctr_q == TO_LAST);

  // Next-state and shared counter: the counter restarts on every state change, so each
  // wait state measures its own timeout from entry; PKT0 waits forever and holds it at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:        if (ctr_q == INIT_LAST) state_d = TX_RST;
      TX_RST:      state_d = WT_RST_SENT;
      WT_RST_SENT: if (bus.BYTE_SENT) state_d = WT_ACK1;
                   else if (tmo)      state_d = INIT;
      WT_ACK1:     if (bus.BYTE_READY) state_d = (good && bus.BYTE_READ == 8'hFA) ? WT_SELFTEST : INIT;
                   else if (tmo)       state_d = INIT;
      WT_SELFTEST: if (bus.BYTE_READY) state_d = (good && bus.BYTE_READ == 8'hAA) ? WT_ID : INIT;
                   else if (tmo)       state_d = INIT;
      WT_ID:       if (bus.BYTE_READY) state_d = (good && bus.BYTE_READ == 8'h00) ? TX_EN : INIT;
                   else if (tmo)       state_d = INIT;
      TX_EN:       state_d = WT_EN_SENT;
      WT_EN_SENT:  if (bus.BYTE_SENT) state_d = WT_ACK2;
                   else if (tmo)      state_d = INIT;
      WT_ACK2:     if (bus.BYTE_READY) state_d = (good && bus.BYTE_READ == 8'hFA) ? PKT0 : INIT;
                   else if (tmo)       state_d = INIT;
      // Status byte must carry the always-one bit 3; anything else is dropped to resync.
      PKT0:        if (good && bus.BYTE_READ[3]) state_d = PKT1;
      PKT1:        if (bad)       state_d = PKT0;
                   else if (good) state_d = PKT2;
                   else if (tmo)  state_d = PKT0;
      PKT2:        if (bad)       state_d = PKT0;
                   else if (good) state_d = PUBLISH;
                   else if (tmo)  state_d = PKT0;
      PUBLISH:     state_d = PKT0;
      default:     state_d = INIT;
    endcase

    ctr_d = ctr_q + CTR_W'(1);
    if (state_d != state_q || state_q == PKT0) ctr_d = '0;
  end

  // State register and cycle counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= INIT;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Registered handshake outputs, decoded from the next state so they line up with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      send_q    <= 1'b0;
      tx_byte_q <= 8'h00;
      rd_en_q   <= 1'b0;
    end else begin
      send_q  <= (state_d == TX_RST) || (state_d == TX_EN);
      rd_en_q <= (state_d != INIT);
      if (state_d == TX_RST)     tx_byte_q <= 8'hFF;
      else if (state_d == TX_EN) tx_byte_q <= 8'hF4;
    end
  end

  // Shadow packet bytes; only a complete packet reaches the MOUSE_* outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s0_q <= 8'h00;
      s1_q <= 8'h00;
      s2_q <= 8'h00;
    end else if (good) begin
      if (state_q == PKT0 && bus.BYTE_READ[3]) s0_q <= bus.BYTE_READ;
      if (state_q == PKT1)                     s1_q <= bus.BYTE_READ;
      if (state_q == PKT2)                     s2_q <= bus.BYTE_READ;
    end
  end

  // Publication: outputs and interrupt update together at the end of the PUBLISH cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      status_q <= 8'h00;
      dx_q     <= 8'h00;
      dy_q     <= 8'h00;
      int_q    <= 1'b0;
    end else begin
      int_q <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        status_q <= s0_q;
        dx_q     <= s1_q;
        dy_q     <= s2_q;
      end
    end
  end

  assign bus.SEND_BYTE      = send_q;
  assign bus.BYTE_TO_SEND   = tx_byte_q;
  assign bus.READ_ENABLE    = rd_en_q;
  assign bus.MOUSE_STATUS   = status_q;
  assign bus.MOUSE_DX       = dx_q;
  assign bus.MOUSE_DY       = dy_q;
  assign bus.SEND_INTERRUPT = int_q;
  assign bus.MASTER_STATE   = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm: directed init/timeout/reset scenarios plus randomized
// stream bytes checked against a packet-assembly model of the mouse protocol.
module tb_mouse_master_sm;
  localparam int ID = 100;
  localparam int TO = 200;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  mouse_master_sm_if bus();

  mouse_master_sm #(.INIT_DELAY(ID), .BYTE_TIMEOUT(TO), .CTR_W(23)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Model: last published packet plus bytes of the packet being assembled.
  logic [7:0] m_stat, m_dx, m_dy;
  logic [7:0] pkt[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " send"},   32'(bus.SEND_BYTE), 0);
    chk({tag, " txbyte"}, 32'(bus.BYTE_TO_SEND), 0);
    chk({tag, " rden"},   32'(bus.READ_ENABLE), 0);
    chk({tag, " status"}, 32'(bus.MOUSE_STATUS), 0);
    chk({tag, " dx"},     32'(bus.MOUSE_DX), 0);
    chk({tag, " dy"},     32'(bus.MOUSE_DY), 0);
    chk({tag, " int"},    32'(bus.SEND_INTERRUPT), 0);
    chk({tag, " state"},  32'(bus.MASTER_STATE), 0);
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    bus.BYTE_READ = b; bus.BYTE_ERROR_CODE = e; bus.BYTE_READY = 1'b1;
    @(negedge CLK);
    bus.BYTE_READY = 1'b0; bus.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic sent_pulse();
    @(negedge CLK); bus.BYTE_SENT = 1'b1;
    @(negedge CLK); bus.BYTE_SENT = 1'b0;
  endtask

  // Wait (bounded) for a command pulse; check its delay from mark, byte and one-cycle width.
  task automatic wait_send(input string tag, input logic [7:0] exp_b, input int exp_cyc,
                           input int mark, input logic [3:0] exp_st);
    int n = 0;
    while (bus.SEND_BYTE !== 1'b1 && n < 1000) begin
      @(posedge CLK); #1; n++;
    end
    chk({tag, " delay"}, 32'(edge_cnt - mark), 32'(exp_cyc));
    chk({tag, " byte"},  32'(bus.BYTE_TO_SEND), 32'(exp_b));
    @(posedge CLK); #1;
    chk({tag, " pulse end"}, 32'(bus.SEND_BYTE), 0);
    chk({tag, " held"},      32'(bus.BYTE_TO_SEND), 32'(exp_b));
    chk({tag, " state"},     32'(bus.MASTER_STATE), 32'(exp_st));
  endtask

  task automatic do_init(input int mark);
    wait_send("tx_rst", 8'hFF, ID, mark, 4'd2);
    sent_pulse();
    chk("wt_ack1", 32'(bus.MASTER_STATE), 3);
    rx(8'hFA, 2'b00); chk("wt_selftest", 32'(bus.MASTER_STATE), 4);
    rx(8'hAA, 2'b00); chk("wt_id", 32'(bus.MASTER_STATE), 5);
    rx(8'h00, 2'b00);
    wait_send("tx_en", 8'hF4, 0, edge_cnt, 4'd7);
    sent_pulse();
    rx(8'hFA, 2'b00);
    chk("pkt0 after init", 32'(bus.MASTER_STATE), 9);
    chk("rden after init", 32'(bus.READ_ENABLE), 1);
  endtask

  // Feed one stream byte and compare against the packet model.
  task automatic feed(input logic [7:0] b, input logic [1:0] e);
    logic exp_int = 1'b0;
    rx(b, e);
    if (e != 2'b00) pkt.delete();
    else if (pkt.size() == 0 && !b[3]) ;
    else begin
      pkt.push_back(b);
      if (pkt.size() == 3) begin
        m_stat = pkt[0]; m_dx = pkt[1]; m_dy = pkt[2];
        pkt.delete();
        exp_int = 1'b1;
      end
    end
    @(posedge CLK); #1;
    chk("pkt int",    32'(bus.SEND_INTERRUPT), 32'(exp_int));
    chk("pkt status", 32'(bus.MOUSE_STATUS), 32'(m_stat));
    chk("pkt dx",     32'(bus.MOUSE_DX), 32'(m_dx));
    chk("pkt dy",     32'(bus.MOUSE_DY), 32'(m_dy));
    chk("pkt state",  32'(bus.MASTER_STATE), 32'(9 + pkt.size()));
    if (exp_int) begin
      @(posedge CLK); #1;
      chk("int one cycle", 32'(bus.SEND_INTERRUPT), 0);
    end
  endtask

  task automatic model_reset();
    m_stat = 8'h00; m_dx = 8'h00; m_dy = 8'h00;
    pkt.delete();
  endtask

  initial begin
    int mark;
    logic [7:0] b;
    logic [1:0] e;
    RESET = 1'b1;
    bus.BYTE_SENT = 1'b0; bus.BYTE_READ = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00; bus.BYTE_READY = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 chk_zero("reset");

    // Nominal init, then the reference packet.
    @(negedge CLK); RESET = 1'b0; mark = edge_cnt;
    chk("rden in init", 32'(bus.READ_ENABLE), 0);
    do_init(mark);
    feed(8'h09, 2'b00); feed(8'h05, 2'b00); feed(8'hFB, 2'b00);
    chk("ref status", 32'(bus.MOUSE_STATUS), 32'h09);
    chk("ref dx",     32'(bus.MOUSE_DX), 32'h05);
    chk("ref dy",     32'(bus.MOUSE_DY), 32'hFB);

    // Resync on bad status byte, then error mid-packet.
    feed(8'h01, 2'b00);
    feed(8'h08, 2'b00);
    feed(8'h05, 2'b01);
    chk("err keeps status", 32'(bus.MOUSE_STATUS), 32'h09);

    // Randomized stream: mostly valid bytes, occasional errors and bad status bytes.
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 9);
      b = 8'($urandom);
      e = 2'b00;
      if (r == 0) e = 2'($urandom_range(1, 3));
      else if (pkt.size() == 0) b[3] = (r != 1);
      feed(b, e);
      repeat ($urandom_range(0, 4)) @(posedge CLK);
      #1;
    end

    // PKT1 inter-byte timeout boundary.
    feed(8'h00, 2'b10);
    feed(8'h18, 2'b00);
    repeat (TO - 2) @(posedge CLK);
    #1 chk("pkt1 before timeout", 32'(bus.MASTER_STATE), 10);
    @(posedge CLK); #1;
    chk("pkt1 timeout", 32'(bus.MASTER_STATE), 9);
    pkt.delete();

    // Bad ACK restarts from INIT and resends 0xFF after the full delay.
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; mark = edge_cnt;
    model_reset();
    wait_send("tx_rst2", 8'hFF, ID, mark, 4'd2);
    sent_pulse();
    rx(8'hFE, 2'b00);
    chk("bad ack state", 32'(bus.MASTER_STATE), 0);
    mark = edge_cnt;
    wait_send("resend", 8'hFF, ID, mark, 4'd2);

    // Self-test timeout boundary, then init restarts.
    sent_pulse();
    rx(8'hFA, 2'b00);
    chk("selftest entry", 32'(bus.MASTER_STATE), 4);
    repeat (TO - 1) @(posedge CLK);
    #1 chk("selftest before timeout", 32'(bus.MASTER_STATE), 4);
    @(posedge CLK); #1;
    chk("selftest timeout", 32'(bus.MASTER_STATE), 0);
    do_init(edge_cnt);
    feed(8'h2C, 2'b00); feed(8'h7F, 2'b00); feed(8'h80, 2'b00);

    // Reset mid-stream between PKT1 and PKT2.
    feed(8'h08, 2'b00); feed(8'h11, 2'b00);
    chk("pkt2 before reset", 32'(bus.MASTER_STATE), 11);
    @(negedge CLK); RESET = 1'b1;
    #1 chk_zero("midreset");
    model_reset();
    @(negedge CLK); RESET = 1'b0; mark = edge_cnt;
    for (int i = 0; i < 3; i++) begin
      rx(8'h08, 2'b00);
      @(posedge CLK); #1;
      chk("ignored in init int",   32'(bus.SEND_INTERRUPT), 0);
      chk("ignored in init state", 32'(bus.MASTER_STATE), 0);
    end
    do_init(mark);
    feed(8'h39, 2'b00); feed(8'h01, 2'b00); feed(8'hFF, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
